trace_buffer: RTL and testbench

TRACE_BUFFER -- requirements
Module: trace_buffer

---
 rtl/trace_buffer.sv | 99 +++++++++
 tb/tb_trace_buffer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer.sv
// rtl/trace_buffer.sv - tagged trace FIFO with IRQ tagging, sticky overflow and trap pulse
// Entries are stored as {tag, payload}; memory is not reset, only pointers and flags.
module trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_branch,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    irq_event,
  input  logic                    clr_ovf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TAG_W+DATA_W-1:0] out_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    trap
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = TAG_W + DATA_W;
  localparam logic [AW:0]      FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE    = AW'(1);
  localparam logic [TAG_W-1:0] TAG_IRQ    = TAG_W'(8);
  localparam logic [TAG_W-1:0] TAG_BRANCH = TAG_W'(1);
  localparam logic [TAG_W-1:0] TAG_PLAIN  = '0;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             irq_latched;
  logic             pop;
  logic             push;
  logic             drop;
  logic [TAG_W-1:0] push_tag;

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // A full buffer still accepts a push when the consumer drains in the same cycle.
  always_comb begin
    pop  = out_valid && out_ready;
    push = in_valid && ((count != FULL_CNT) || pop);
    drop = in_valid && !push;
    if (irq_latched || irq_event) begin
      push_tag = TAG_IRQ;
    end else if (in_branch) begin
      push_tag = TAG_BRANCH;
    end else begin
      push_tag = TAG_PLAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {push_tag, in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      irq_latched <= 1'b0;
      overflow    <= 1'b0;
      trap        <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      if (push) begin
        irq_latched <= 1'b0;
      end else if (irq_event) begin
        irq_latched <= 1'b1;
      end
      // A drop beats a simultaneous clear; trap marks only the 0->1 transition.
      trap <= drop && !overflow;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trace_buffer.sv
// tb/tb_trace_buffer.sv - randomized self-checking bench for trace_buffer against a queue model
// Inputs change #1 after the rising edge; outputs are compared in the same window.
module tb_trace_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int TW    = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_branch = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          irq_event = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [TW+DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          overflow;
  logic          trap;

  int checks = 0;
  int errors = 0;

  logic [TW+DW-1:0] q [$];
  bit m_irq;
  bit m_ovf;
  bit m_trap;

  trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_branch(in_branch), .in_data(in_data),
    .irq_event(irq_event), .clr_ovf(clr_ovf), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count), .overflow(overflow), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    check_eq("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check_eq("count", 64'(count), 64'(q.size()));
    check_eq("overflow", 64'(overflow), 64'(m_ovf));
    check_eq("trap", 64'(trap), 64'(m_trap));
    if (q.size() != 0) check_eq("out_data", 64'(out_data), 64'(q[0]));
  endtask

  task automatic model_reset();
    q.delete();
    m_irq = 1'b0;
    m_ovf = 1'b0;
    m_trap = 1'b0;
  endtask

  task automatic cycle(input logic iv, input logic br, input logic [DW-1:0] d,
                       input logic irq, input logic clr, input logic rdy);
    bit pop, push, drop;
    logic [TW-1:0] tag;
    in_valid = iv; in_branch = br; in_data = d;
    irq_event = irq; clr_ovf = clr; out_ready = rdy;
    check_state();
    pop  = (q.size() != 0) && rdy;
    push = iv && ((q.size() < DEPTH) || pop);
    drop = iv && !push;
    tag  = (m_irq || irq) ? TW'(8) : (br ? TW'(1) : TW'(0));
    if (pop) void'(q.pop_front());
    if (push) q.push_back({tag, d});
    if (push) m_irq = 1'b0;
    else if (irq) m_irq = 1'b1;
    m_trap = drop && !m_ovf;
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; irq_event = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    check_state();

    // Branch push appears one cycle later with BRANCH tag.
    cycle(1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    check_eq("r033_valid", 64'(out_valid), 64'd1);
    check_eq("r033_data", 64'(out_data), 64'h1_1111_1111);
    check_eq("r033_count", 64'(count), 64'd1);

    // Latched IRQ tags the next push only.
    do_reset();
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    cycle(1'b1, 1'b1, 32'h0000_00A5, 1'b0, 1'b0, 1'b0);
    check_eq("r034_irq_data", 64'(out_data), 64'h8_0000_00A5);
    cycle(1'b1, 1'b0, 32'h0000_0077, 1'b0, 1'b0, 1'b1);
    check_eq("r034_plain_data", 64'(out_data), 64'h0_0000_0077);
    // IRQ coinciding with a push is consumed by that push.
    cycle(1'b1, 1'b1, 32'h0000_0033, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_0044, 1'b0, 1'b0, 1'b0);
    check_eq("r019_tail", 64'(q[q.size()-1]), 64'h1_0000_0044);

    // Fill, then overflow and trap behaviour.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(32'h100 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0000_DEAD, 1'b0, 1'b0, 1'b0);
    check_eq("r035_count", 64'(count), 64'd16);
    check_eq("r035_ovf", 64'(overflow), 64'd1);
    check_eq("r035_trap", 64'(trap), 64'd1);
    idle(1'b0);
    check_eq("r035_trap_once", 64'(trap), 64'd0);
    cycle(1'b1, 1'b0, 32'h0000_BEEF, 1'b0, 1'b1, 1'b0);
    check_eq("r035_second_trap", 64'(trap), 64'd0);
    check_eq("r028_drop_wins", 64'(overflow), 64'd1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_eq("r028_cleared", 64'(overflow), 64'd0);

    // Push+pop while full keeps count at DEPTH.
    cycle(1'b1, 1'b0, 32'h0000_0042, 1'b0, 1'b0, 1'b1);
    check_eq("r036_count", 64'(count), 64'd16);
    check_eq("r036_head", 64'(out_data), 64'h0_0000_0101);
    repeat (DEPTH - 1) idle(1'b1);
    check_eq("r036_last", 64'(out_data), 64'h0_0000_0042);
    check_eq("r036_last_count", 64'(count), 64'd1);
    idle(1'b1);

    // Streaming across pointer wrap.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'(i & 1), DW'(32'hC000 + i), 1'b0, 1'b0, 1'b1);
      check_eq("r037_count_le1", 64'(count <= 1), 64'd1);
    end
    check_eq("r037_ovf", 64'(overflow), 64'd0);
    idle(1'b1);

    // Asynchronous reset at count 7 with overflow set.
    do_reset();
    for (int i = 0; i <= DEPTH; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0, 1'b0, 1'b0);
    repeat (DEPTH - 7) idle(1'b1);
    check_eq("r038_pre_count", 64'(count), 64'd7);
    check_eq("r038_pre_ovf", 64'(overflow), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("r038_async_valid", 64'(out_valid), 64'd0);
    check_eq("r038_async_count", 64'(count), 64'd0);
    check_eq("r038_async_ovf", 64'(overflow), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle(1'b1, 1'b0, 32'h0000_5A5A, 1'b0, 1'b0, 1'b0);
    check_eq("r032_first_push", 64'(out_data), 64'h0_0000_5A5A);

    // Randomized traffic with phases of slow and fast draining.
    for (int i = 0; i < 1500; i++) begin
      int rdy_pct;
      rdy_pct = ((i / 100) % 3 == 0) ? 15 : (((i / 100) % 3 == 1) ? 85 : 50);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 99) < 70, 1'($urandom), DW'($urandom),
              $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
              $urandom_range(0, 99) < rdy_pct);
      end
    end
    check_state();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
